// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter run controller: FSM encoding and default widths.
package counter_ctrl_pkg;

  localparam int unsigned DEF_WIDTH      = 4;
  localparam int unsigned DEF_PRESCALE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/counter_ctrl_dp.sv
// Counter datapath: count register, prescale divider and the run configuration latched at start.
module counter_ctrl_dp
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic                  adv_en,
  input  logic                  hold_at_limit,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tick,
  output logic                  at_limit
);

  logic [WIDTH-1:0]      limit_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [PRESCALE_W-1:0] pdiv;

  // Divider phase complete; the count only moves when the controller also grants adv_en.
  assign tick     = (pdiv == prescale_q);
  assign at_limit = (count == limit_q);

  // Config latch, count and divider; load (restart) outranks clr (abort) outranks advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      limit_q    <= '0;
      prescale_q <= '0;
      count      <= '0;
      pdiv       <= '0;
    end else if (load) begin
      limit_q    <= limit;
      prescale_q <= prescale;
      count      <= '0;
      pdiv       <= '0;
    end else if (clr) begin
      count <= '0;
      pdiv  <= '0;
    end else if (adv_en) begin
      if (tick) begin
        pdiv <= '0;
        if (!at_limit) begin
          count <= count + WIDTH'(1);
        end else if (!hold_at_limit) begin
          // Explicit wrap so limit values below all-ones behave the same as all-ones.
          count <= '0;
        end
      end else begin
        pdiv <= pdiv + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Run controller for the counter datapath: command decode, run FSM and done/wrap pulses.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  hold,
  input  logic                  oneshot,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap,
  output logic [1:0]            state
);

  state_t state_q, state_d;
  logic   oneshot_q;
  logic   done_q, done_d;
  logic   wrap_q, wrap_d;
  logic   clr, load, adv_en;
  logic   tick, at_limit;

  counter_ctrl_dp #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) u_dp (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .load          (load),
    .adv_en        (adv_en),
    .hold_at_limit (oneshot_q),
    .limit         (limit),
    .prescale      (prescale),
    .count         (count),
    .tick          (tick),
    .at_limit      (at_limit)
  );

  // Next-state and datapath controls; priority is stop > start > hold > tick.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    load    = 1'b0;
    adv_en  = 1'b0;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    if (stop && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      clr     = 1'b1;
    end else if (start && !stop) begin
      // A stop in IDLE is ignored but still suppresses a simultaneous start.
      state_d = ST_RUN;
      load    = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_RUN, ST_HOLD: begin
          if (hold) begin
            state_d = ST_HOLD;
          end else begin
            // Releasing hold resumes counting on the same edge, so a hold costs its own length.
            state_d = ST_RUN;
            adv_en  = 1'b1;
            if (tick && at_limit) begin
              if (oneshot_q) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                wrap_d = 1'b1;
              end
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, latched mode and status pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      oneshot_q <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      if (load) begin
        oneshot_q <= oneshot;
      end
    end
  end

  assign busy  = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign done  = done_q;
  assign wrap  = wrap_q;
  assign state = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: a behavioural model predicts each cycle, a monitor compares.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, hold = 1'b0, oneshot = 1'b0;
  logic [3:0] limit = '0;
  logic [7:0] prescale = '0;
  logic [3:0] count;
  logic       busy, done, wrap;
  logic [1:0] state;

  counter_ctrl #(
    .WIDTH      (4),
    .PRESCALE_W (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .hold     (hold),
    .oneshot  (oneshot),
    .limit    (limit),
    .prescale (prescale),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap),
    .state    (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int count;
    int state;
    int busy;
    int done;
    int wrap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Model: a run is described by k, the number of advancing edges since start.
  int m_state = 0, m_k = 0, m_l = 0, m_p = 0, m_os = 0, m_count = 0, m_done = 0, m_wrap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_k = 0; m_l = 0; m_p = 0; m_os = 0; m_count = 0; m_done = 0; m_wrap = 0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit h, input bit os,
                            input int lim, input int ps, output exp_t e);
    int period;
    m_done = 0;
    m_wrap = 0;
    if (sp && m_state != 0) begin
      m_state = 0;
      m_count = 0;
    end else if (st && !sp) begin
      m_l = lim; m_p = ps; m_os = os; m_k = 0; m_count = 0; m_state = 1;
    end else if (m_state == 3) begin
      m_state = 0;
    end else if (m_state == 1 || m_state == 2) begin
      if (h) begin
        m_state = 2;
      end else begin
        m_state = 1;
        m_k++;
        period = (m_l + 1) * (m_p + 1);
        if (m_os != 0 && m_k == period) begin
          m_state = 3;
          m_done  = 1;
          m_count = m_l;
        end else begin
          m_count = (m_k / (m_p + 1)) % (m_l + 1);
          if (m_os == 0 && (m_k % period) == 0) m_wrap = 1;
        end
      end
    end
    e.count = m_count;
    e.state = m_state;
    e.busy  = (m_state == 1 || m_state == 2) ? 1 : 0;
    e.done  = m_done;
    e.wrap  = m_wrap;
  endtask

  // One cycle of stimulus: drive at the falling edge, queue the outcome of the next rising edge.
  task automatic drive(input bit st, input bit sp, input bit h, input bit os,
                       input int lim, input int ps);
    exp_t e;
    @(negedge clk);
    start = st; stop = sp; hold = h; oneshot = os;
    limit = 4'(lim); prescale = 8'(ps);
    model_step(st, sp, h, os, lim & 15, ps & 255, e);
    sb.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  // Edges from the start-sampling edge to the done pulse, with optional hold window.
  task automatic oneshot_latency(input string name, input int lim, input int ps,
                                 input int hold_at, input int hold_len);
    int got;
    int lo;
    lo  = hold_at * (ps + 1);
    got = -1;
    drive(1, 0, 0, 1, lim, ps);
    @(posedge clk); #3;
    for (int n = 1; n <= 600 && got < 0; n++) begin
      drive(0, 0, (n > lo && n <= lo + hold_len), $urandom_range(0, 1),
            $urandom_range(0, 15), $urandom_range(0, 255));
      @(posedge clk); #3;
      if (done === 1'b1) got = n;
    end
    check(name, got, (lim + 1) * (ps + 1) + hold_len);
  endtask

  // Free-run: first wrap and the spacing of later wraps must equal the full period.
  task automatic freerun_period(input string name, input int lim, input int ps);
    int last;
    int wraps;
    int period;
    period = (lim + 1) * (ps + 1);
    last   = 0;
    wraps  = 0;
    drive(1, 0, 0, 0, lim, ps);
    @(posedge clk); #3;
    for (int n = 1; n <= 600 && wraps < 3; n++) begin
      drive(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255));
      @(posedge clk); #3;
      if (wrap === 1'b1) begin
        check(name, n - last, period);
        last = n;
        wraps++;
      end
    end
    check({name, "_count"}, wraps, 3);
  endtask

  // Monitor: after each rising edge, compare DUT outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("count", {28'b0, count}, e.count);
        check("state", {30'b0, state}, e.state);
        check("busy", {31'b0, busy}, e.busy);
        check("done", {31'b0, done}, e.done);
        check("wrap", {31'b0, wrap}, e.wrap);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit r_hold;
    r_hold = 1'b0;
    model_reset();
    #1;
    check("rst_count", {28'b0, count}, 0);
    check("rst_state", {30'b0, state}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    @(negedge clk);
    rst = 1'b0;

    // One-shot, prescale 0, and the limit=0 / prescale=2 corner.
    oneshot_latency("lat_oneshot_l3_p0", 3, 0, 0, 0);
    idle_cycles(2);
    oneshot_latency("lat_oneshot_l0_p2", 0, 2, 0, 0);
    idle_cycles(2);
    // Hold for 5 cycles at count 4 delays done by exactly 5.
    oneshot_latency("lat_hold_l9_p0", 9, 0, 4, 5);
    idle_cycles(2);

    // Free-run periods, including the full 4-bit range and limit=0.
    freerun_period("wrap_l2_p1", 2, 1);
    freerun_period("wrap_l15_p0", 15, 0);
    freerun_period("wrap_l0_p3", 0, 3);
    drive(0, 1, 0, 0, 0, 0);

    // Stop at count 6, then restart mid-run at count 7 with limit 2.
    drive(1, 0, 0, 1, 9, 0);
    idle_cycles(6);
    drive(0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 9, 0);
    idle_cycles(7);
    oneshot_latency("lat_restart_l2_p0", 2, 0, 0, 0);
    // Simultaneous start and stop while running.
    drive(1, 0, 0, 0, 9, 0);
    idle_cycles(3);
    drive(1, 1, 0, 0, 5, 0);
    idle_cycles(2);

    // Asynchronous reset between edges at count 5 in RUN.
    drive(1, 0, 0, 1, 9, 0);
    idle_cycles(5);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_count", {28'b0, count}, 0);
    check("arst_state", {30'b0, state}, 0);
    check("arst_busy", {31'b0, busy}, 0);
    check("arst_done", {31'b0, done}, 0);
    check("arst_wrap", {31'b0, wrap}, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized commands and config, including mid-run config churn.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) r_hold = ~r_hold;
      drive($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 3, r_hold,
            $urandom_range(0, 1), $urandom_range(0, 15),
            ($urandom_range(0, 99) < 85) ? $urandom_range(0, 2) : $urandom_range(0, 255));
    end
    idle_cycles(2);

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk); #3;
    end
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
